stream_frame_arbiter: RTL

- Shares one 16-bit actor output stream among NUM_IN upstream actor streams. All streams use the SEND/ACK/RDY/COUNT token handshake of the image-processing actors.
- Grants a whole frame of FRAME_TOKENS tokens to one requester at a time. Arbitration between frames is round-robin.
- Sits between parallel image actors (e.g. per-channel image stages) and a single downstream consumer such as a saliency combiner or output port.

---
 rtl/stream_frame_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/stream_frame_arbiter.sv
// Round-robin frame arbiter: grants whole frames of FRAME_TOKENS tokens from NUM_IN actor streams to one output.
// Optional stall watchdog that abandons a starved frame is enabled with `define ARB_TIMEOUT_EN.
module stream_frame_arbiter #(
  parameter int NUM_IN         = 4,
  parameter int FRAME_TOKENS   = 16384,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_IN-1:0]      In_SEND,
  input  logic [16*NUM_IN-1:0]   In_DATA,
  input  logic [16*NUM_IN-1:0]   In_COUNT,
  output logic [NUM_IN-1:0]      In_ACK,
  input  logic                   Out_RDY,
  input  logic                   Out_ACK,
  output logic                   Out_SEND,
  output logic [15:0]            Out_DATA,
  output logic [15:0]            Out_COUNT,
  output logic [NUM_IN-1:0]      Grant,
  output logic                   Frame_done,
  output logic                   Timeout
);

  localparam int SW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(FRAME_TOKENS + 1);
  localparam logic [CW-1:0] LAST_TOK = CW'(FRAME_TOKENS - 1);
  localparam logic [SW-1:0] LAST_IN  = SW'(NUM_IN - 1);
  localparam logic [SW:0]   NUM_IN_W = (SW+1)'(NUM_IN);
  localparam logic [31:0]   TO_W     = 32'(TIMEOUT_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]        state_r;
  logic [SW-1:0]     sel_r;
  logic [SW-1:0]     rr_ptr_r;
  logic [CW-1:0]     tok_cnt_r;
  logic [15:0]       data_r;
  logic [SW-1:0]     winner_s;
  logic [SW:0]       cand_s;
  logic [SW-1:0]     sel_inc_s;
  logic [NUM_IN-1:0] sel_oh_s;
  logic              req_any_s;
  logic              xfer_s;
  logic              last_s;
  logic              abort_s;
  logic              unused_s;
  logic [15:0]       in_data_s [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign in_data_s[k] = In_DATA[16*k +: 16];
  end

  // Round-robin search from rr_ptr; lower offsets override higher ones so the first hit wins.
  always_comb begin
    winner_s = rr_ptr_r;
    cand_s   = {(SW+1){1'b0}};
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      cand_s = {1'b0, rr_ptr_r} + (SW+1)'(i);
      cand_s = (cand_s >= NUM_IN_W) ? (cand_s - NUM_IN_W) : cand_s;
      winner_s = In_SEND[cand_s[SW-1:0]] ? cand_s[SW-1:0] : winner_s;
    end
  end

  assign req_any_s = |In_SEND;
  assign sel_inc_s = (sel_r == LAST_IN) ? {SW{1'b0}} : (sel_r + SW'(1));
  assign sel_oh_s  = {{(NUM_IN-1){1'b0}}, 1'b1} << sel_r;
  assign xfer_s    = (state_r == ST_XFER) && In_SEND[sel_r] && Out_RDY;
  assign last_s    = xfer_s && (tok_cnt_r == LAST_TOK);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] stall_cnt_r;
  logic          stall_s;

  assign stall_s = (state_r == ST_XFER) && !In_SEND[sel_r];
  assign abort_s = stall_s && (stall_cnt_r == TO_LAST);

  // Counts consecutive cycles the owner has nothing to send; any other cycle restarts it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_r <= {TW{1'b0}};
    end else if (!stall_s || abort_s) begin
      stall_cnt_r <= {TW{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + TW'(1);
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Frame FSM: one arbitration cycle in IDLE, then FRAME_TOKENS transfers in XFER.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      sel_r     <= {SW{1'b0}};
      rr_ptr_r  <= {SW{1'b0}};
      tok_cnt_r <= {CW{1'b0}};
      data_r    <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            sel_r     <= winner_s;
            tok_cnt_r <= {CW{1'b0}};
            state_r   <= ST_XFER;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (last_s || abort_s) begin
            rr_ptr_r  <= sel_inc_s;
            tok_cnt_r <= {CW{1'b0}};
            state_r   <= ST_IDLE;
          end else if (xfer_s) begin
            tok_cnt_r <= tok_cnt_r + CW'(1);
          end else begin
            state_r   <= ST_XFER;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      if (xfer_s) begin
        data_r <= in_data_s[sel_r];
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Data is driven combinationally during a transfer and otherwise holds the last token sent.
  assign Out_SEND   = xfer_s;
  assign Out_DATA   = xfer_s ? in_data_s[sel_r] : data_r;
  assign Out_COUNT  = 16'd1;
  assign In_ACK     = xfer_s ? sel_oh_s : {NUM_IN{1'b0}};
  assign Grant      = (state_r == ST_XFER) ? sel_oh_s : {NUM_IN{1'b0}};
  assign Frame_done = last_s;
  assign Timeout    = abort_s;

  assign unused_s = ^{In_COUNT, Out_ACK, TO_W};

endmodule
